// File: rtl/toggle_period_meter.sv
// Measures the clock-cycle distance between successive toggles of y_in and hands each
// period downstream over valid/ready. Optional glitch filter: TOGGLE_PERIOD_GLITCH_FILTER_EN.
module toggle_period_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             y_in,
    input  logic             enable,
    input  logic             period_ready,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             period_sat,
    output logic             overrun
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             y_lvl;
    logic             y_s;
    logic             y_prev;
    logic             edge_det;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             res_fire;
    logic             res_sat;

`ifdef TOGGLE_PERIOD_GLITCH_FILTER_EN
    logic y_smp;
    logic y_flt;

    // The level only follows y_in once two consecutive samples agree.
    always_ff @(posedge clock) begin
        if (reset) begin
            y_smp <= 1'b0;
            y_flt <= 1'b0;
        end else begin
            y_smp <= y_in;
            if (y_in == y_smp) begin
                y_flt <= y_in;
            end
        end
    end

    assign y_lvl = y_flt;
`else
    assign y_lvl = y_in;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            y_s    <= 1'b0;
            y_prev <= 1'b0;
        end else begin
            y_s    <= y_lvl;
            y_prev <= y_s;
        end
    end

    assign edge_det = y_s ^ y_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (edge_det && enable) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt  = cnt;
        res_fire = 1'b0;
        res_sat  = (cnt == CNT_MAX);
        case (state)
            IDLE: begin
                cnt_nxt = (edge_det && enable) ? CNT_ONE : '0;
            end
            MEASURE: begin
                if (!enable) begin
                    cnt_nxt = '0;
                end else if (edge_det) begin
                    res_fire = 1'b1;
                    cnt_nxt  = CNT_ONE;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // A new result may replace one being accepted in the same cycle, so valid never bubbles.
    always_ff @(posedge clock) begin
        if (reset) begin
            period_out   <= '0;
            period_sat   <= 1'b0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (res_fire) begin
            if (!period_valid || period_ready) begin
                period_out   <= cnt;
                period_sat   <= res_sat;
                period_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (period_valid && period_ready) begin
            period_valid <= 1'b0;
        end
    end

endmodule

// File: doc/toggle_period_meter.md
Name: toggle_period_meter

Overview:
- Downstream consumer of the T flip-flop output `y`. Measures the clock-cycle distance between successive toggles of `y` (either polarity).
- Hands each measured period to the next stage over a valid/ready handshake.
- Used to characterise toggle activity (`t` duty and randomness) in hardware instead of by waveform inspection.

Parameters:
- CNT_W, 16, width of the period counter and of `period_out`; the counter saturates at 2^CNT_W-1.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- y_in  input  1  toggling level from the T flip-flop `y` output. Same clock domain, already synchronous.
- enable  input  1  measurement enable.
- period_ready  input  1  downstream accepts the result when high together with `period_valid`.
- period_out  output  CNT_W  measured period in clock cycles.
- period_valid  output  1  `period_out`/`period_sat` hold an unconsumed result.
- period_sat  output  1  the result saturated (true period ≥ 2^CNT_W-1).
- overrun  output  1  sticky flag: a result was dropped because the previous one was still pending.

Behaviour:
- Reset (synchronous, priority over everything):
  - `y_s`, `y_prev`, counter, `period_out`, `period_valid`, `period_sat` and `overrun` all cleared to 0.
  - State goes to IDLE.
  - Reset mid-measurement or with a pending result discards both.
- Edge detect:
  - `y_s <= y_lvl`; `y_prev <= y_s`; `edge = y_s ^ y_prev`.
  - `y_lvl = y_in` (see Optional Feature).
  - A change on `y_in` before clock edge k raises `edge` in the cycle after k. The resulting action occurs at edge k+1.
  - `period_valid` is first seen high after edge k+1, i.e. 2-cycle latency.
- FSM, 2 states:
  - IDLE:
    - Counter held at 0.
    - `edge && enable` -> MEASURE, counter <= 1. This first edge produces no result.
  - MEASURE:
    - `!enable` -> IDLE, counter <= 0. Any pending result is kept.
    - Else `edge`: produce result = counter value (with its saturation bit); counter <= 1; stay in MEASURE.
    - Else: counter <= counter+1, saturating at all-ones; the saturation bit is set while the counter is at all-ones.
- Period definition: toggles on consecutive clocks give 1; toggles N clocks apart give N.
- Output handshake:
  - Result produced and (`!period_valid` or `period_ready`): load `period_out`/`period_sat`, `period_valid` <= 1.
    - This applies to a simultaneous accept and new result: `valid` stays 1 with the new data, no bubble.
  - Result produced while `period_valid && !period_ready`: new result dropped, `overrun` <= 1. Held data is unchanged.
  - No result and `period_valid && period_ready`: `period_valid` <= 0; data holds its last value.
  - `period_out`/`period_sat` are stable while `period_valid && !period_ready`.
  - `overrun` clears only on reset.
- `enable` low does not block the output handshake.

Optional Feature:
- Macro: TOGGLE_PERIOD_GLITCH_FILTER_EN.
- Defined:
  - `y_lvl` is a filtered level: it updates to `y_in` only after `y_in` has held the same value on 2 consecutive clock samples. One-cycle pulses on `y_in` are ignored.
  - Adds 1 cycle of latency, 3 total. Measured periods are unchanged for toggles ≥2 cycles apart.
  - Filter registers reset to 0.
- Undefined: `y_lvl = y_in` directly, latency 2. Toggles every cycle are measured as 1.

Test Plan:
- Reset: hold `reset`=1 for 2 cycles with `y_in`=1, `enable`=1 -> all outputs 0. A spurious edge after release only arms MEASURE; no `period_valid`.
- Periodic input: `enable`=1, `period_ready`=1, `y_in` toggles every 4 cycles -> no result on the first edge, then `period_out`=4, `period_sat`=0, and `period_valid` pulses one cycle per toggle, 2 cycles after each toggle.
- T flip-flop chained: drive the T flip-flop with `t`=1 and feed its `y` to `y_in`.
  - Without the macro: `period_out`=1 with `period_valid` high continuously.
  - With TOGGLE_PERIOD_GLITCH_FILTER_EN: `y_in` toggles every cycle, never holds a value for 2 samples, so the filter never updates and no results appear.
- Saturation: CNT_W=4, a toggle, then 20 quiet cycles, then a toggle -> `period_out`=15, `period_sat`=1. The next 3-cycle period gives `period_out`=3, `period_sat`=0.
- Backpressure: `period_ready`=0 across two results of 5 then 6 -> `period_out`=5 held, `overrun`=1. `period_ready`=1 for one cycle -> `period_valid` drops; `overrun` stays 1.
- Mid-operation: drop `enable` 2 cycles into a period, then re-enable -> the first edge after re-enable gives no result. Assert `reset` with `period_valid`=1 -> `period_valid`=0 next cycle.
